// File: rtl/div_pkg.sv
// Shared encodings and sizing for the EXE-stage iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_ITER = 32;

endpackage

// File: rtl/div_datapath.sv
// Radix-2 restoring divide datapath: operand magnitudes, one
// shift/subtract step per strobe, and sign fix-up into the result registers.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_ITER
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_fix_sign,
    input  logic             i_signed,
    input  logic [DIV_W-1:0] i_src1,
    input  logic [DIV_W-1:0] i_src2,
    output logic [DIV_W-1:0] o_quotient,
    output logic [DIV_W-1:0] o_remainder
);

    localparam int unsigned PR_W = DIV_W + 1;

    function automatic logic [DIV_W-1:0] neg_if(input logic n, input logic [DIV_W-1:0] v);
        return n ? (~v + DIV_W'(1)) : v;
    endfunction

    // Partial remainder is always below the divisor between steps, so only
    // the shifted value needs the extra bit.
    logic [DIV_W-1:0] r_pr;
    logic [DIV_W-1:0] r_qw;
    logic [DIV_W-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [DIV_W-1:0] r_quo;
    logic [DIV_W-1:0] r_rem;

    logic             w_neg1;
    logic             w_neg2;
    logic [DIV_W-1:0] w_mag1;
    logic [DIV_W-1:0] w_mag2;
    logic [PR_W-1:0]  w_shift;
    logic [PR_W-1:0]  w_diff;
    logic             w_qbit;
    logic [DIV_W-1:0] w_pr_next;
    logic [DIV_W-1:0] w_qw_next;

    assign w_neg1 = i_signed & i_src1[DIV_W-1];
    assign w_neg2 = i_signed & i_src2[DIV_W-1];
    assign w_mag1 = neg_if(w_neg1, i_src1);
    assign w_mag2 = neg_if(w_neg2, i_src2);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shift   = {r_pr, r_qw[DIV_W-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[PR_W-1];
    assign w_pr_next = w_qbit ? w_diff[DIV_W-1:0] : w_shift[DIV_W-1:0];
    assign w_qw_next = {r_qw[DIV_W-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pr     <= '0;
            r_qw     <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
        end else begin
            if (i_load) begin
                r_pr     <= '0;
                r_qw     <= w_mag1;
                r_dvs    <= w_mag2;
                // Divide by zero keeps the all-ones quotient unsigned-looking.
                r_sign_q <= (w_neg1 ^ w_neg2) & (|i_src2);
                r_sign_r <= w_neg1;
            end else if (i_step) begin
                r_pr <= w_pr_next;
                r_qw <= w_qw_next;
            end
            if (i_fix_sign) begin
                r_quo <= neg_if(r_sign_q, w_qw_next);
                r_rem <= neg_if(r_sign_r, w_pr_next);
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/exe_div_ctrl.sv
// EXE-stage divide sequencer: starts on a valid div request, stalls the
// stage until the result is ready, holds it for MEM, and aborts on cancel.
module exe_div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_ITER
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [DIV_W-1:0] div_src1,
    input  logic [DIV_W-1:0] div_src2,
    input  logic             div_accept,
    input  logic             div_cancel,
    output logic             div_ready_go,
    output logic             div_busy,
    output logic [DIV_W-1:0] div_quotient,
    output logic [DIV_W-1:0] div_remainder
);

    localparam int unsigned      CNT_W    = $clog2(DIV_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_load;
    logic w_step;
    logic w_fix_sign;

    // Cancel suppresses every datapath update, including the final one.
    assign w_load     = (r_state == DIV_IDLE) & div_req & ~div_cancel;
    assign w_step     = (r_state == DIV_BUSY) & ~div_cancel;
    assign w_fix_sign = w_step & (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
        end else if (div_cancel) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (div_req) begin
                        r_state <= DIV_BUSY;
                        r_cnt   <= '0;
                    end
                end
                DIV_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (div_accept) begin
                        r_state <= DIV_IDLE;
                    end
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    div_datapath #(
        .DIV_W (DIV_W)
    ) u_datapath (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_fix_sign  (w_fix_sign),
        .i_signed    (div_signed),
        .i_src1      (div_src1),
        .i_src2      (div_src2),
        .o_quotient  (div_quotient),
        .o_remainder (div_remainder)
    );

    assign div_ready_go = ~div_req | (r_state == DIV_DONE);
    assign div_busy     = (r_state == DIV_BUSY);

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Directed and randomized checks of exe_div_ctrl against an arithmetic
// reference model of signed/unsigned divide.
module tb_exe_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        div_req;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_accept;
    logic        div_cancel;
    logic        div_ready_go;
    logic        div_busy;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exe_div_ctrl #(.DIV_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .div_req       (div_req),
        .div_signed    (div_signed),
        .div_src1      (div_src1),
        .div_src2      (div_src2),
        .div_accept    (div_accept),
        .div_cancel    (div_cancel),
        .div_ready_go  (div_ready_go),
        .div_busy      (div_busy),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: divide magnitudes, then quotient takes the xor of signs and
    // the remainder takes the dividend sign; divide by zero is fixed.
    function automatic void ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ma;
        logic [31:0] mb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            return;
        end
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sg && (a[31] ^ b[31])) q = -q;
        if (sg && a[31])           r = -r;
    endfunction

    // Present a request this cycle; return cycles until ready_go rises.
    task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        div_signed = sg;
        div_src1   = a;
        div_src2   = b;
        div_req    = 1'b1;
        lat        = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin
                chk("busy_after_start", 32'(div_busy), 32'd1);
                chk("stall_while_busy", 32'(div_ready_go), 32'd0);
                div_src1 = $urandom;
                div_src2 = $urandom;
            end
            if (div_ready_go) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_case(input string tag, input bit sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        run_div(sg, a, b, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd33);
        chk({tag, "_quo"}, div_quotient, eq);
        chk({tag, "_rem"}, div_remainder, er);
        div_accept = 1'b1;
        tick();
        div_accept = 1'b0;
        div_req    = 1'b0;
    endtask

    initial begin
        int          lat;
        int          c0;
        logic [31:0] eq;
        logic [31:0] er;
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;

        resetn = 1'b0; div_req = 1'b0; div_signed = 1'b0;
        div_src1 = '0; div_src2 = '0; div_accept = 1'b0; div_cancel = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_quo", div_quotient, 32'd0);
        chk("rst_rem", div_remainder, 32'd0);
        chk("rst_ready_go", 32'(div_ready_go), 32'd1);
        resetn = 1'b1;
        tick();

        // 100 / 7 unsigned, then confirm IDLE (not DONE) one cycle after accept.
        run_div(1'b0, 32'd100, 32'd7, lat);
        chk("u100_7_latency", 32'(lat), 32'd33);
        chk("u100_7_quo", div_quotient, 32'd14);
        chk("u100_7_rem", div_remainder, 32'd2);
        div_accept = 1'b1;
        tick();
        div_accept = 1'b0;
        #1;
        chk("idle_after_accept_busy", 32'(div_busy), 32'd0);
        chk("idle_after_accept_rg", 32'(div_ready_go), 32'd0);
        div_req = 1'b0;
        #1;
        chk("idle_rg_no_req", 32'(div_ready_go), 32'd1);
        tick();

        do_case("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_case("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        do_case("s_div0", 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        do_case("u_div0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        do_case("u_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);

        // Hold in DONE without accept, then back-to-back request.
        run_div(1'b0, 32'd50, 32'd5, lat);
        chk("hold_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_quo", div_quotient, 32'd10);
            chk("hold_rem", div_remainder, 32'd0);
            chk("hold_ready_go", 32'(div_ready_go), 32'd1);
        end
        div_accept = 1'b1;
        c0 = cyc;
        tick();
        div_accept = 1'b0;
        run_div(1'b0, 32'd81, 32'd9, lat);
        chk("b2b_gap", 32'(cyc - c0), 32'd34);
        chk("b2b_quo", div_quotient, 32'd9);
        chk("b2b_rem", div_remainder, 32'd0);
        div_accept = 1'b1;
        tick();
        div_accept = 1'b0;

        // Cancel at cnt == 10 with the request still raised.
        div_signed = 1'b0; div_src1 = 32'd1000; div_src2 = 32'd3; div_req = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        div_cancel = 1'b1;
        tick();
        div_cancel = 1'b0;
        chk("cancel_busy", 32'(div_busy), 32'd0);
        chk("cancel_quo_held", div_quotient, 32'd9);
        chk("cancel_rem_held", div_remainder, 32'd0);
        do_case("after_cancel_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Cancel and accept together in DONE.
        run_div(1'b0, 32'd20, 32'd6, lat);
        chk("ca_latency", 32'(lat), 32'd33);
        div_accept = 1'b1; div_cancel = 1'b1;
        tick();
        div_accept = 1'b0; div_cancel = 1'b0;
        chk("ca_not_done", 32'(div_ready_go), 32'd0);
        chk("ca_quo", div_quotient, 32'd3);
        chk("ca_rem", div_remainder, 32'd2);
        div_req = 1'b0;
        tick();

        // Reset at cnt == 20.
        div_signed = 1'b1; div_src1 = $urandom; div_src2 = 32'd7; div_req = 1'b1;
        for (int i = 0; i < 21; i++) tick();
        chk("pre_rst_busy", 32'(div_busy), 32'd1);
        resetn = 1'b0;
        tick();
        div_req = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(div_busy), 32'd0);
        chk("mid_rst_quo", div_quotient, 32'd0);
        chk("mid_rst_rem", div_remainder, 32'd0);
        chk("mid_rst_rg", 32'(div_ready_go), 32'd1);
        resetn = 1'b1;
        tick();

        for (int k = 0; k < 16; k++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = (k == 3) ? 32'd0 : 32'($urandom_range(16, 4096));
            endcase
            ref_div(sg, a, b, eq, er);
            do_case("rand", sg, a, b, eq, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
